capture_sequencer: RTL



---
 rtl/capture_sequencer_if.sv | 22 ++
 rtl/capture_sequencer.sv | 117 +++++++++++
 2 files changed

// File: rtl/capture_sequencer_if.sv
// capture_sequencer_if: UDP header request plus the sample-in and payload-out byte streams.
interface capture_sequencer_if;
    logic        hdr_valid;
    logic        hdr_ready;
    logic [15:0] udp_length;
    logic [7:0]  src_tdata;
    logic        src_tvalid;
    logic        src_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        tx_done;
    modport master (
        output hdr_valid, udp_length, src_tready, m_tdata, m_tvalid, m_tlast,
        input  hdr_ready, src_tdata, src_tvalid, m_tready, tx_done
    );
    modport slave (
        input  hdr_valid, udp_length, src_tready, m_tdata, m_tvalid, m_tlast,
        output hdr_ready, src_tdata, src_tvalid, m_tready, tx_done
    );
endinterface

// File: rtl/capture_sequencer.sv
// capture_sequencer: turns one start pulse into a burst of UDP packets, each a
// big-endian sequence number followed by DATA_BYTES bytes from the sample buffer.
module capture_sequencer #(
    parameter int DATA_BYTES       = 1024,
    parameter int PKTS_PER_CAPTURE = 64,
    parameter int GAP_CYCLES       = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    output logic                       busy,
    output logic                       done,
    output logic                       aborted,
    output logic [15:0]                pkt_count,
    output logic [15:0]                seq_num,
    capture_sequencer_if.master        bus
);
    typedef enum logic [2:0] {IDLE, HDR, SEQ_HI, SEQ_LO, DATA, WAIT_DONE, GAP} state_t;
    localparam logic [15:0] LAST_BEAT = 16'(DATA_BYTES - 1);
    localparam logic [15:0] LAST_PKT  = 16'(PKTS_PER_CAPTURE - 1);
    localparam logic [31:0] LAST_GAP  = 32'(GAP_CYCLES - 1);
    state_t      state_q, state_d;
    logic [15:0] byte_q, byte_d, pkt_count_q, pkt_count_d, seq_num_q, seq_num_d;
    logic [31:0] gap_q, gap_d;
    logic        pend_q, pend_d, aborted_q, aborted_d, done_q, done_d;
    logic        busy_q, busy_d, hdr_valid_q, hdr_valid_d;
    logic        beat;
    assign beat = (state_q == DATA) && bus.src_tvalid && bus.m_tready;
    always_comb begin
        state_d     = state_q;
        byte_d      = byte_q;
        pkt_count_d = pkt_count_q;
        seq_num_d   = seq_num_q;
        gap_d       = gap_q;
        aborted_d   = aborted_q;
        // an abort once the header is accepted only takes effect after tx_done
        pend_d      = pend_q | (abort && (state_q inside {SEQ_HI, SEQ_LO, DATA, WAIT_DONE}));
        case (state_q)
            IDLE: if (start) begin
                state_d     = HDR;
                pkt_count_d = '0;
                aborted_d   = 1'b0;
                pend_d      = 1'b0;
            end
            HDR: if (abort) begin
                state_d   = IDLE;
                aborted_d = 1'b1;
            end else if (bus.hdr_ready) state_d = SEQ_HI;
            SEQ_HI: if (bus.m_tready) state_d = SEQ_LO;
            SEQ_LO: if (bus.m_tready) begin
                state_d = DATA;
                byte_d  = '0;
            end
            DATA: if (beat) begin
                byte_d = byte_q + 16'd1;
                if (byte_q == LAST_BEAT) state_d = WAIT_DONE;
            end
            WAIT_DONE: if (bus.tx_done) begin
                pkt_count_d = pkt_count_q + 16'd1;
                seq_num_d   = seq_num_q + 16'd1;
                gap_d       = '0;
                if (pkt_count_q == LAST_PKT || pend_d) begin
                    state_d   = IDLE;
                    aborted_d = pend_d;
                end else state_d = (GAP_CYCLES == 0) ? HDR : GAP;
            end
            GAP: if (abort) begin
                state_d   = IDLE;
                aborted_d = 1'b1;
            end else if (gap_q == LAST_GAP) state_d = HDR;
            else gap_d = gap_q + 32'd1;
            default: state_d = IDLE;
        endcase
        busy_d      = state_d != IDLE;
        hdr_valid_d = state_d == HDR;
        done_d      = (state_q != IDLE) && (state_d == IDLE);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            byte_q      <= '0;
            pkt_count_q <= '0;
            seq_num_q   <= '0;
            gap_q       <= '0;
            pend_q      <= 1'b0;
            aborted_q   <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            hdr_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_q      <= byte_d;
            pkt_count_q <= pkt_count_d;
            seq_num_q   <= seq_num_d;
            gap_q       <= gap_d;
            pend_q      <= pend_d;
            aborted_q   <= aborted_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            hdr_valid_q <= hdr_valid_d;
        end
    end
    assign busy           = busy_q;
    assign done           = done_q;
    assign aborted        = aborted_q;
    assign pkt_count      = pkt_count_q;
    assign seq_num        = seq_num_q;
    assign bus.hdr_valid  = hdr_valid_q;
    assign bus.udp_length = 16'(DATA_BYTES + 10);
    assign bus.src_tready = (state_q == DATA) && bus.m_tready;
    assign bus.m_tvalid   = (state_q == SEQ_HI) || (state_q == SEQ_LO) || ((state_q == DATA) && bus.src_tvalid);
    assign bus.m_tlast    = (state_q == DATA) && (byte_q == LAST_BEAT);
    assign bus.m_tdata    = (state_q == SEQ_HI) ? seq_num_q[15:8] :
                            (state_q == SEQ_LO) ? seq_num_q[7:0]  :
                            (state_q == DATA)   ? bus.src_tdata   : 8'h00;
endmodule
